// File: rtl/tt_scan_pkg.sv
// Shared types and sizes for the truth-table scan checker.
package tt_scan_pkg;

    localparam int N_VEC = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // True in the states where the function under test is being driven with idx.
    function automatic logic drives_vector(input scan_state_t st);
        return (st == SETTLE) || (st == SAMPLE);
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter holding the per-vector settle wait.
// expire is high while the count reads 1, i.e. in the last settle cycle.
module tt_settle_timer
    import tt_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Load on request, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= value;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == CNT_ONE);

endmodule

// File: rtl/tt_scan_checker.sv
// Walks all 16 {a,b,c,d} vectors into a combinational block, samples s_in
// after a settle wait, builds the truth table and compares it with expected.
module tt_scan_checker
    import tt_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_VEC-1:0]  expected,
    input  logic              s_in,
    output logic [IDX_W-1:0]  abcd,
    output logic              busy,
    output logic              done,
    output logic [N_VEC-1:0]  tt,
    output logic              match,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [IDX_W-1:0]  first_fail
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
    localparam logic [IDX_W-1:0] IDX_ZERO    = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_VEC - 1);
    localparam logic [CNT_W-1:0] MC_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] MC_ONE      = CNT_W'(1);

    scan_state_t      state_r;
    scan_state_t      state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             accept_s;
    logic             mism_s;
    logic             timer_load_s;
    logic             timer_expire_s;
    logic [N_VEC-1:0] tt_nxt_s;
    logic [CNT_W-1:0] mc_nxt_s;
    logic [IDX_W-1:0] ff_nxt_s;
    logic             match_nxt_s;
    logic [IDX_W-1:0] abcd_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    assign accept_s     = (state_r == IDLE) && start;
    assign mism_s       = s_in ^ expected[idx_r];
    assign timer_load_s = accept_s || ((state_r == SAMPLE) && (idx_r != LAST_IDX));

    tt_settle_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load_s),
        .value  (SETTLE_LOAD),
        .expire (timer_expire_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = tt_scan_pkg::SETTLE;
                else       state_nxt_s = IDLE;
            end
            tt_scan_pkg::SETTLE: begin
                if (timer_expire_s) state_nxt_s = SAMPLE;
                else                state_nxt_s = tt_scan_pkg::SETTLE;
            end
            SAMPLE: begin
                if (idx_r == LAST_IDX) state_nxt_s = DONE;
                else                   state_nxt_s = tt_scan_pkg::SETTLE;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs, computed for the coming state so they can be registered.
    always_comb begin
        abcd_nxt_s = IDX_ZERO;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                abcd_nxt_s = IDX_ZERO;
            end
            tt_scan_pkg::SETTLE, SAMPLE: begin
                abcd_nxt_s = drives_vector(state_nxt_s) ? idx_nxt_s : IDX_ZERO;
                busy_nxt_s = 1'b1;
            end
            DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                abcd_nxt_s = IDX_ZERO;
            end
        endcase
    end

    // Vector index, capture and compare next values.
    always_comb begin
        idx_nxt_s   = idx_r;
        tt_nxt_s    = tt;
        mc_nxt_s    = mismatch_count;
        ff_nxt_s    = first_fail;
        match_nxt_s = match;
        if (accept_s) begin
            idx_nxt_s   = IDX_ZERO;
            tt_nxt_s    = {N_VEC{1'b0}};
            mc_nxt_s    = MC_ZERO;
            ff_nxt_s    = IDX_ZERO;
            match_nxt_s = 1'b0;
        end else if (state_r == SAMPLE) begin
            tt_nxt_s[idx_r] = s_in;
            if (mism_s) begin
                mc_nxt_s = mismatch_count + MC_ONE;
                // Only the first mismatch of a scan records its index.
                if (mismatch_count == MC_ZERO) ff_nxt_s = idx_r;
                else                           ff_nxt_s = first_fail;
            end else begin
                mc_nxt_s = mismatch_count;
            end
            if (idx_r != LAST_IDX) idx_nxt_s = idx_r + IDX_ONE;
            else                   idx_nxt_s = idx_r;
        end else if (state_r == DONE) begin
            match_nxt_s = (mismatch_count == MC_ZERO);
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r          <= IDX_ZERO;
            abcd           <= IDX_ZERO;
            busy           <= 1'b0;
            done           <= 1'b0;
            tt             <= {N_VEC{1'b0}};
            match          <= 1'b0;
            mismatch_count <= MC_ZERO;
            first_fail     <= IDX_ZERO;
        end else begin
            idx_r          <= idx_nxt_s;
            abcd           <= abcd_nxt_s;
            busy           <= busy_nxt_s;
            done           <= done_nxt_s;
            tt             <= tt_nxt_s;
            match          <= match_nxt_s;
            mismatch_count <= mc_nxt_s;
            first_fail     <= ff_nxt_s;
        end
    end

endmodule

// File: tb/tb_tt_scan_checker.sv
// Scoreboard bench: two checkers (SETTLE=1 with a zero-delay function model,
// SETTLE=3 with a function model delayed two cycles) driven with directed and
// random expected masks; monitors pop expected results when done pulses.
module tb_tt_scan_checker;

    typedef struct {
        logic [15:0] tt;
        int          mc;
        int          ff;
        logic        match;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    logic        start_a, start_b;
    logic [15:0] expected_a, expected_b;
    logic [3:0]  abcd_a, abcd_b;
    logic        s_a, s_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] tt_a, tt_b;
    logic        match_a, match_b;
    logic [4:0]  mc_a, mc_b;
    logic [3:0]  ff_a, ff_b;
    logic [3:0]  d1_b, d2_b;

    int c0_a = 0, c0_b = 0;
    int dcyc_a = 0, dcyc_b = 0;
    int ndone_a = 0;
    logic seen_a = 1'b0, seen_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function under test: s = (b|c)&(a|~b|~c)&(~a|~b|d)
    function automatic logic f_model(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (b | c) & (a | ~b | ~c) & (~a | ~b | d);
    endfunction

    function automatic logic [15:0] ref_table();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = f_model(4'(i));
        return t;
    endfunction

    function automatic exp_t make_exp(input logic [15:0] m, input int c0, input int per);
        exp_t e;
        logic [15:0] diff;
        e.tt = ref_table();
        diff = e.tt ^ m;
        e.mc = $countones(diff);
        e.ff = 0;
        for (int i = 15; i >= 0; i--) if (diff[i]) e.ff = i;
        e.match = (e.mc == 0);
        e.done_cyc = c0 + 16 * per;
        return e;
    endfunction

    assign s_a = f_model(abcd_a);
    assign s_b = f_model(d2_b);
    always @(posedge clk) begin
        d1_b <= abcd_b;
        d2_b <= d1_b;
    end

    tt_scan_checker #(.SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a), .s_in(s_a),
        .abcd(abcd_a), .busy(busy_a), .done(done_a), .tt(tt_a), .match(match_a),
        .mismatch_count(mc_a), .first_fail(ff_a)
    );

    tt_scan_checker #(.SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b), .s_in(s_b),
        .abcd(abcd_b), .busy(busy_b), .done(done_b), .tt(tt_b), .match(match_b),
        .mismatch_count(mc_b), .first_fail(ff_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A: checks results the cycle after done, plus timing and the abcd walk.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_a = 1'b0;
        end else begin
            if (seen_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_done", 32'(q_a.size()), 32'd1);
                end else begin
                    ea = q_a.pop_front();
                    check("a_tt", 32'(tt_a), 32'(ea.tt));
                    check("a_mismatch_count", 32'(mc_a), 32'(ea.mc));
                    check("a_first_fail", 32'(ff_a), 32'(ea.ff));
                    check("a_match", 32'(match_a), 32'(ea.match));
                    check("a_done_cycle", 32'(dcyc_a), 32'(ea.done_cyc));
                end
            end
            seen_a = done_a;
            if (done_a) begin
                ndone_a++;
                dcyc_a = cyc;
                check("a_busy_in_done", 32'(busy_a), 32'd0);
            end
            if (busy_a) check("a_abcd_walk", 32'(abcd_a), 32'((cyc - c0_a) / 2));
        end
    end

    // Monitor B: same checks for the SETTLE=3 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_b = 1'b0;
        end else begin
            if (seen_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_done", 32'(q_b.size()), 32'd1);
                end else begin
                    eb = q_b.pop_front();
                    check("b_tt", 32'(tt_b), 32'(eb.tt));
                    check("b_mismatch_count", 32'(mc_b), 32'(eb.mc));
                    check("b_first_fail", 32'(ff_b), 32'(eb.ff));
                    check("b_match", 32'(match_b), 32'(eb.match));
                    check("b_done_cycle", 32'(dcyc_b), 32'(eb.done_cyc));
                end
            end
            seen_b = done_b;
            if (done_b) begin
                dcyc_b = cyc;
                check("b_busy_in_done", 32'(busy_b), 32'd0);
            end
            if (busy_b) check("b_abcd_walk", 32'(abcd_b), 32'((cyc - c0_b) / 4));
        end
    end

    task automatic start_a_scan(input logic [15:0] m);
        @(negedge clk);
        expected_a = m;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        c0_a = cyc;
        q_a.push_back(make_exp(m, cyc, 2));
    endtask

    task automatic start_b_scan(input logic [15:0] m);
        @(negedge clk);
        expected_b = m;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        c0_b = cyc;
        q_b.push_back(make_exp(m, cyc, 4));
    endtask

    task automatic wait_done(input logic sel_b);
        int k = 0;
        while (((sel_b ? done_b : done_a) !== 1'b1) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(sel_b ? "b_done_timeout" : "a_done_timeout",
              32'(sel_b ? done_b : done_a), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_abcd_a"}, 32'(abcd_a), 32'd0);
        check({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        check({tag, "_done_a"}, 32'(done_a), 32'd0);
        check({tag, "_tt_a"}, 32'(tt_a), 32'd0);
        check({tag, "_match_a"}, 32'(match_a), 32'd0);
        check({tag, "_mc_a"}, 32'(mc_a), 32'd0);
        check({tag, "_ff_a"}, 32'(ff_a), 32'd0);
        check({tag, "_abcd_b"}, 32'(abcd_b), 32'd0);
        check({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        check({tag, "_done_b"}, 32'(done_b), 32'd0);
        check({tag, "_tt_b"}, 32'(tt_b), 32'd0);
        check({tag, "_match_b"}, 32'(match_b), 32'd0);
        check({tag, "_mc_b"}, 32'(mc_b), 32'd0);
        check({tag, "_ff_b"}, 32'(ff_b), 32'd0);
    endtask

    initial begin
        logic [15:0] m;
        logic [15:0] rt;
        int k;
        int nd0;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        expected_a = 16'h0000;
        expected_b = 16'h0000;
        rt = ref_table();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: exact match, one-bit mismatch, all-bits mismatch.
        start_a_scan(16'hAC3C);
        wait_done(1'b0);
        check("a_tt_const", 32'(tt_a), 32'h0000AC3C);
        check("a_match_const", 32'(match_a), 32'd1);
        start_a_scan(16'hAC3D);
        wait_done(1'b0);
        check("a_mc_one_const", 32'(mc_a), 32'd1);
        start_a_scan(16'h53C3);
        wait_done(1'b0);
        check("a_mc_all_const", 32'(mc_a), 32'd16);

        // Slow settle with a delayed function model.
        start_b_scan(16'hAC3C);
        wait_done(1'b1);
        check("b_tt_const", 32'(tt_b), 32'h0000AC3C);

        // Second start while running is ignored.
        nd0 = ndone_a;
        start_a_scan(16'h1234);
        k = 0;
        while (abcd_a !== 4'd5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0);
        repeat (40) @(negedge clk);
        check("a_single_done", 32'(ndone_a - nd0), 32'd1);

        // Reset during vector 9 discards the scan.
        start_b_scan(16'hFFFF);
        k = 0;
        while (abcd_b !== 4'd9 && k < 200) begin
            @(negedge clk);
            k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_b_scan(16'hAC3C);
        wait_done(1'b1);
        check("b_after_reset_tt", 32'(tt_b), 32'h0000AC3C);
        check("b_after_reset_match", 32'(match_b), 32'd1);

        // Randomized masks on both instances.
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0:       m = 16'($urandom);
                1:       m = rt ^ (16'd1 << $urandom_range(0, 15));
                2:       m = rt;
                default: m = ~rt ^ 16'($urandom & 32'h0000_00F0);
            endcase
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                start_a_scan(m);
                wait_done(1'b0);
            end else begin
                start_b_scan(m);
                wait_done(1'b1);
            end
        end

        repeat (5) @(negedge clk);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
